// File: rtl/marquee_scroller_if.sv
// Bus bundle for the marquee scroller: message writes, length load,
// scroll control and the registered window outputs.
interface marquee_scroller_if #(
    parameter int DIGITS  = 4,
    parameter int CODE_W  = 5,
    parameter int MAX_LEN = 16
);
    localparam int ADDR_W = $clog2(MAX_LEN);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [CODE_W-1:0]        wr_data;
    logic                     len_load;
    logic [ADDR_W:0]          len_val;
    logic                     run;
    logic                     direction;
    logic                     step;
    logic [DIGITS*CODE_W-1:0] codes;
    logic [ADDR_W-1:0]        offset;
    logic                     wrap;

    modport master (
        output wr_en, wr_addr, wr_data, len_load, len_val,
        output run, direction, step,
        input  codes, offset, wrap
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len_load, len_val,
        input  run, direction, step,
        output codes, offset, wrap
    );
endinterface

// File: rtl/marquee_scroller.sv
// Scrolling-message engine: message buffer plus a DIGITS-wide rotating
// window with free-run, single-step and end-of-message dwell.
module marquee_scroller #(
    parameter int              DIGITS      = 4,
    parameter int              CODE_W      = 5,
    parameter int              MAX_LEN     = 16,
    parameter int              TICK_DIV    = 50000000,
    parameter int              DWELL_TICKS = 2,
    parameter logic [CODE_W-1:0] BLANK     = 5'd31
) (
    input logic               clk,
    input logic               rst,
    marquee_scroller_if.slave bus
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int PS_W   = $clog2(TICK_DIV);
    localparam int DW_W   = (DWELL_TICKS < 1) ? 1 : $clog2(DWELL_TICKS + 1);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [DW_W-1:0] DW_LAST =
        DW_W'((DWELL_TICKS > 0) ? DWELL_TICKS - 1 : 0);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [ADDR_W:0] LEN_RST = (ADDR_W + 1)'(DIGITS);

    typedef enum logic [1:0] {HOLD, SCROLL, DWELL} state_t;

    state_t                   state_q, state_d;
    logic [PS_W-1:0]          ps_q, ps_d;
    logic [DW_W-1:0]          dw_q, dw_d;
    logic [ADDR_W-1:0]        off_q, off_d;
    logic [ADDR_W:0]          len_q;
    logic                     wrap_q, wrap_d;
    logic [CODE_W-1:0]        mem_q [MAX_LEN];
    logic [DIGITS*CODE_W-1:0] codes_q, codes_d;

    logic                     tick;
    logic                     len_ok;
    logic                     adv;
    logic [ADDR_W:0]          last;
    logic [ADDR_W-1:0]        adv_off;
    logic                     adv_wrap;
    logic [ADDR_W:0]          idx;
    logic [ADDR_W:0]          nxt;

    assign tick   = (state_q != HOLD) && (ps_q == PS_LAST);
    assign len_ok = bus.len_load && (bus.len_val != '0) &&
                    (bus.len_val <= LEN_MAX);
    assign last   = len_q - 1'b1;

    // Candidate offset and wrap flag for one advance in the sampled direction
    always_comb begin
        adv_off  = off_q;
        adv_wrap = 1'b0;
        if (bus.direction) begin
            adv_wrap = ({1'b0, off_q} == last);
            adv_off  = adv_wrap ? '0 : off_q + 1'b1;
        end else begin
            adv_wrap = (off_q == '0);
            adv_off  = adv_wrap ? last[ADDR_W-1:0] : off_q - 1'b1;
        end
    end

    // Next state, prescaler, dwell count and advance request
    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        dw_d    = dw_q;
        adv     = 1'b0;
        unique case (state_q)
            HOLD: begin
                ps_d = '0;
                dw_d = '0;
                if (bus.run) begin
                    state_d = SCROLL;
                end else if (bus.step) begin
                    adv = 1'b1;
                end
            end
            SCROLL: begin
                if (!bus.run) begin
                    state_d = HOLD;
                    ps_d    = '0;
                    dw_d    = '0;
                end else begin
                    ps_d = tick ? '0 : ps_q + 1'b1;
                    if (tick) begin
                        adv  = 1'b1;
                        dw_d = '0;
                        if (adv_wrap && (DWELL_TICKS > 0)) begin
                            state_d = DWELL;
                        end
                    end
                end
            end
            DWELL: begin
                if (!bus.run) begin
                    state_d = HOLD;
                    ps_d    = '0;
                    dw_d    = '0;
                end else begin
                    ps_d = tick ? '0 : ps_q + 1'b1;
                    if (tick) begin
                        if (dw_q == DW_LAST) begin
                            state_d = SCROLL;
                            dw_d    = '0;
                        end else begin
                            dw_d = dw_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = HOLD;
                ps_d    = '0;
                dw_d    = '0;
            end
        endcase
        // A length load rewinds the window and cancels any pending advance
        if (len_ok) begin
            adv  = 1'b0;
            ps_d = '0;
            dw_d = '0;
            if (state_d == DWELL) begin
                state_d = SCROLL;
            end
        end
    end

    assign off_d  = len_ok ? '0 : (adv ? adv_off : off_q);
    assign wrap_d = adv && adv_wrap;

    // Window gather: walk msg_len-modulo indices by conditional wrap-to-zero
    always_comb begin
        codes_d = '0;
        idx     = {1'b0, off_q};
        nxt     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            codes_d[(DIGITS-1-i)*CODE_W +: CODE_W] = mem_q[idx[ADDR_W-1:0]];
            nxt = idx + 1'b1;
            idx = (nxt >= len_q) ? '0 : nxt;
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HOLD;
            ps_q    <= '0;
            dw_q    <= '0;
            off_q   <= '0;
            len_q   <= LEN_RST;
            wrap_q  <= 1'b0;
            codes_q <= {DIGITS{BLANK}};
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            dw_q    <= dw_d;
            off_q   <= off_d;
            wrap_q  <= wrap_d;
            codes_q <= codes_d;
            if (len_ok) begin
                len_q <= bus.len_val;
            end
        end
    end

    // Message buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_q[i] <= BLANK;
            end
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < LEN_MAX)) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.codes  = codes_q;
    assign bus.offset = off_q;
    assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_marquee_scroller.sv
// Directed bench for marquee_scroller: step-mode vector table plus
// hand sequences for free-run, dwell, length load and reset.
module tb_marquee_scroller;
    localparam int B = 31;

    typedef struct {
        logic       wr;
        logic [3:0] wa;
        logic [4:0] wd;
        logic       ll;
        logic [4:0] lv;
        logic       dir;
        logic       st;
        logic [3:0] eo;
        logic       ew;
        logic [19:0] ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   cnt;
    vec_t tbl[$];

    marquee_scroller_if #(.DIGITS(4), .CODE_W(5), .MAX_LEN(16)) bus ();

    marquee_scroller #(
        .DIGITS(4), .CODE_W(5), .MAX_LEN(16),
        .TICK_DIV(4), .DWELL_TICKS(2), .BLANK(5'd31)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] c4(int a, int b, int c, int d);
        return {a[4:0], b[4:0], c[4:0], d[4:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_change(output int n);
        logic [3:0] old;
        old = bus.offset;
        n = 0;
        do begin
            tick1();
            n++;
        end while (bus.offset == old && n < 40);
    endtask

    task automatic adv_chk(string name, int n_exp, int off, logic w);
        wait_change(cnt);
        chk({name, "_dly"}, cnt, n_exp);
        chk({name, "_off"}, bus.offset, off);
        chk({name, "_wrap"}, bus.wrap, w);
    endtask

    task automatic add(logic wr, int wa, int wd, logic ll, int lv,
                       logic dir, logic st, int eo, logic ew,
                       logic [19:0] ec);
        vec_t v;
        v.wr = wr; v.wa = wa[3:0]; v.wd = wd[4:0];
        v.ll = ll; v.lv = lv[4:0]; v.dir = dir; v.st = st;
        v.eo = eo[3:0]; v.ew = ew; v.ec = ec;
        tbl.push_back(v);
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.len_load = 0; bus.len_val = 0;
        bus.run = 0; bus.direction = 0; bus.step = 0;

        add(1, 0, 0, 0, 0,  0, 0, 0,  0, c4(0, B, B, B));
        add(1, 1, 1, 0, 0,  0, 0, 0,  0, c4(0, 1, B, B));
        add(1, 2, 2, 0, 0,  0, 0, 0,  0, c4(0, 1, 2, B));
        add(1, 3, 3, 0, 0,  0, 0, 0,  0, c4(0, 1, 2, 3));
        add(1, 4, 4, 0, 0,  0, 0, 0,  0, c4(0, 1, 2, 3));
        add(1, 5, 5, 0, 0,  0, 0, 0,  0, c4(0, 1, 2, 3));
        add(0, 0, 0, 1, 6,  0, 0, 0,  0, c4(0, 1, 2, 3));
        add(0, 0, 0, 1, 0,  0, 0, 0,  0, c4(0, 1, 2, 3));
        add(0, 0, 0, 1, 17, 0, 0, 0,  0, c4(0, 1, 2, 3));
        add(0, 0, 0, 0, 0,  0, 1, 5,  1, c4(5, 0, 1, 2));
        add(0, 0, 0, 0, 0,  1, 1, 0,  1, c4(0, 1, 2, 3));
        add(0, 0, 0, 0, 0,  1, 1, 1,  0, c4(1, 2, 3, 4));
        add(1, 2, 9, 0, 0,  1, 1, 2,  0, c4(9, 3, 4, 5));
        add(1, 2, 2, 0, 0,  1, 0, 2,  0, c4(2, 3, 4, 5));
        add(0, 0, 0, 1, 2,  1, 0, 0,  0, c4(0, 1, 0, 1));
        add(0, 0, 0, 0, 0,  1, 1, 1,  0, c4(1, 0, 1, 0));
        add(0, 0, 0, 0, 0,  1, 1, 0,  1, c4(0, 1, 0, 1));
        add(0, 0, 0, 1, 1,  1, 0, 0,  0, c4(0, 0, 0, 0));
        add(0, 0, 0, 0, 0,  0, 1, 0,  1, c4(0, 0, 0, 0));
        add(0, 0, 0, 1, 16, 0, 0, 0,  0, c4(0, 1, 2, 3));
        add(0, 0, 0, 0, 0,  0, 1, 15, 1, c4(B, 0, 1, 2));
        add(0, 0, 0, 1, 6,  0, 0, 0,  0, c4(0, 1, 2, 3));
        add(0, 0, 0, 1, 2,  1, 1, 0,  0, c4(0, 1, 0, 1));
        add(0, 0, 0, 1, 6,  1, 0, 0,  0, c4(0, 1, 2, 3));

        #23;
        chk("rst_codes", bus.codes, 20'hFFFFF);
        chk("rst_off", bus.offset, 0);
        chk("rst_wrap", bus.wrap, 0);
        @(posedge clk);
        #1 rst = 1;

        foreach (tbl[i]) begin
            bus.wr_en = tbl[i].wr; bus.wr_addr = tbl[i].wa;
            bus.wr_data = tbl[i].wd; bus.len_load = tbl[i].ll;
            bus.len_val = tbl[i].lv; bus.direction = tbl[i].dir;
            bus.step = tbl[i].st;
            tick1();
            chk($sformatf("vec%0d_off", i), bus.offset, tbl[i].eo);
            chk($sformatf("vec%0d_wrap", i), bus.wrap, tbl[i].ew);
            bus.wr_en = 0; bus.len_load = 0; bus.step = 0;
            tick1();
            chk($sformatf("vec%0d_codes", i), bus.codes, tbl[i].ec);
        end

        bus.direction = 1;
        bus.run = 1;
        adv_chk("run_first", 5, 1, 0);
        for (int k = 2; k <= 5; k++)
            adv_chk($sformatf("run%0d", k), 4, k, 0);
        adv_chk("run_wrap", 4, 0, 1);
        tick1();
        chk("wrap_pulse_end", bus.wrap, 0);
        chk("wrap_codes", bus.codes, c4(0, 1, 2, 3));
        adv_chk("dwell_exit", 11, 1, 0);

        bus.step = 1;
        repeat (3) tick1();
        chk("step_in_scroll", bus.offset, 1);
        bus.step = 0;
        adv_chk("after_step", 1, 2, 0);
        tick1();
        chk("scroll_codes", bus.codes, c4(2, 3, 4, 5));
        adv_chk("run3b", 3, 3, 0);
        adv_chk("run4b", 4, 4, 0);
        adv_chk("run5b", 4, 5, 0);
        adv_chk("wrap_b", 4, 0, 1);
        repeat (2) tick1();
        bus.run = 0;
        repeat (10) tick1();
        chk("hold_frozen", bus.offset, 0);
        bus.run = 1;
        adv_chk("rerun", 5, 1, 0);

        bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 7;
        tick1();
        bus.wr_addr = 1; bus.wr_data = 8;
        tick1();
        bus.wr_en = 0;
        tick1();
        bus.len_load = 1; bus.len_val = 2;
        tick1();
        bus.len_load = 0;
        chk("ll_tick_off", bus.offset, 0);
        chk("ll_tick_wrap", bus.wrap, 0);
        tick1();
        chk("ll_tick_codes", bus.codes, c4(7, 8, 7, 8));
        adv_chk("len2_a", 3, 1, 0);
        adv_chk("len2_wrap", 4, 0, 1);
        bus.len_load = 1; bus.len_val = 6;
        tick1();
        bus.len_load = 0;
        chk("ll_dwell_off", bus.offset, 0);
        adv_chk("ll_dwell_exit", 4, 1, 0);

        #2 rst = 0;
        #1;
        chk("async_codes", bus.codes, 20'hFFFFF);
        chk("async_off", bus.offset, 0);
        chk("async_wrap", bus.wrap, 0);
        bus.run = 0;
        repeat (2) tick1();
        rst = 1;
        repeat (6) tick1();
        chk("post_rst_off", bus.offset, 0);
        chk("post_rst_codes", bus.codes, 20'hFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
